// File: rtl/mag_arbiter_if.sv
// mag_arbiter_if: request, datapath and result signals of mag_arbiter
// slave: arbiter side (takes requests and magnitudes, drives grants, samples, results)
// master: environment side (requesters, shared magnitude datapath, result consumer)
interface mag_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W = 2
);
  logic [NUM_CH*DATA_WIDTH-1:0] req_i, req_q;
  logic [NUM_CH-1:0] req_valid, req_ready;
  logic [DATA_WIDTH-1:0] dp_i, dp_q, dp_mag, out_mag;
  logic dp_valid, dp_mag_stb, out_valid, tag_err;
  logic [CH_W-1:0] out_ch;
  modport slave (
    input req_i, req_q, req_valid, dp_mag, dp_mag_stb,
    output req_ready, dp_i, dp_q, dp_valid, out_mag, out_ch, out_valid, tag_err
  );
  modport master (
    output req_i, req_q, req_valid, dp_mag, dp_mag_stb,
    input req_ready, dp_i, dp_q, dp_valid, out_mag, out_ch, out_valid, tag_err
  );
endinterface

// File: rtl/mag_arbiter.sv
// mag_arbiter: round-robin arbiter feeding a shared magnitude datapath, tagging results by channel
// clock, reset (sync, active-high, wins over enable), enable (global advance)
// bus.slave: req_i/req_q/req_valid/req_ready per-channel requests; dp_i/dp_q/dp_valid sample out;
//   dp_mag/dp_mag_stb magnitude in; out_mag/out_ch/out_valid result; tag_err sticky tag error
// MAG_ARB_THRESH_EN adds thresh input and sticky per-channel out_over flags
module mag_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int MAG_LATENCY = 3,
  parameter int CH_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
`ifdef MAG_ARB_THRESH_EN
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic [NUM_CH-1:0] out_over,
`endif
  mag_arbiter_if.slave bus
);
  localparam int DEPTH = MAG_LATENCY + 1;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d, gnt_ch, idx;
  logic [CH_W:0] sum;
  logic gnt_any, acc, tail_vld, hit, stray, drop;
  logic [DEPTH-1:0] vld_q, vld_d, grd_q, grd_d;
  logic [DEPTH-1:0][CH_W-1:0] ch_q, ch_d;
  logic [DATA_WIDTH-1:0] dp_i_q, dp_i_d, dp_q_q, dp_q_d, out_mag_q, out_mag_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic dp_valid_q, out_valid_q, out_valid_d, tag_err_q, tag_err_d;
  // Scan from the farthest candidate back toward rr_ptr so the nearest valid channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch = '0;
    sum = '0;
    idx = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(n);
      idx = sum >= (CH_W + 1)'(NUM_CH) ? CH_W'(sum - (CH_W + 1)'(NUM_CH)) : CH_W'(sum);
      gnt_any = gnt_any | bus.req_valid[idx];
      gnt_ch = bus.req_valid[idx] ? idx : gnt_ch;
    end
  end
  assign acc = gnt_any & enable & ~reset;
  assign bus.req_ready = acc ? NUM_CH'(1) << gnt_ch : '0;
  assign tail_vld = vld_q[DEPTH-1];
  assign hit = bus.dp_mag_stb & tail_vld;
  // Guard bits fill the tag pipe on reset so strobes flushed out of the datapath
  // after a reset are not mistaken for stray strobes.
  assign stray = bus.dp_mag_stb & ~tail_vld & ~grd_q[DEPTH-1];
  assign drop = ~bus.dp_mag_stb & tail_vld;
  always_comb begin
    rr_ptr_d = acc ? (gnt_ch == CH_W'(NUM_CH - 1) ? '0 : gnt_ch + CH_W'(1)) : rr_ptr_q;
    vld_d = {vld_q[DEPTH-2:0], acc};
    grd_d = {grd_q[DEPTH-2:0], 1'b0};
    ch_d = {ch_q[DEPTH-2:0], gnt_ch};
    dp_i_d = acc ? bus.req_i[int'(gnt_ch)*DATA_WIDTH +: DATA_WIDTH] : dp_i_q;
    dp_q_d = acc ? bus.req_q[int'(gnt_ch)*DATA_WIDTH +: DATA_WIDTH] : dp_q_q;
    out_valid_d = hit;
    out_mag_d = hit ? bus.dp_mag : out_mag_q;
    out_ch_d = hit ? ch_q[DEPTH-1] : out_ch_q;
    tag_err_d = tag_err_q | stray | drop;
  end
  always_ff @(posedge clock)
    if (reset) begin
      rr_ptr_q <= '0;
      vld_q <= '0;
      grd_q <= '1;
      ch_q <= '0;
      dp_i_q <= '0;
      dp_q_q <= '0;
      dp_valid_q <= 1'b0;
      out_mag_q <= '0;
      out_ch_q <= '0;
      out_valid_q <= 1'b0;
      tag_err_q <= 1'b0;
    end else if (enable) begin
      rr_ptr_q <= rr_ptr_d;
      vld_q <= vld_d;
      grd_q <= grd_d;
      ch_q <= ch_d;
      dp_i_q <= dp_i_d;
      dp_q_q <= dp_q_d;
      dp_valid_q <= acc;
      out_mag_q <= out_mag_d;
      out_ch_q <= out_ch_d;
      out_valid_q <= out_valid_d;
      tag_err_q <= tag_err_d;
    end
  assign bus.dp_i = dp_i_q;
  assign bus.dp_q = dp_q_q;
  assign bus.dp_valid = dp_valid_q;
  assign bus.out_mag = out_mag_q;
  assign bus.out_ch = out_ch_q;
  // A result registered just before enable drops stays held and reappears on resume.
  assign bus.out_valid = out_valid_q & enable;
  assign bus.tag_err = tag_err_q;
`ifdef MAG_ARB_THRESH_EN
  logic [NUM_CH-1:0] over_q, over_d;
  assign over_d = over_q | (hit && bus.dp_mag >= thresh ? NUM_CH'(1) << ch_q[DEPTH-1] : '0);
  always_ff @(posedge clock)
    if (reset) over_q <= '0;
    else if (enable) over_q <= over_d;
  assign out_over = over_q;
`endif
endmodule

// File: tb/tb_mag_arbiter.sv
// tb_mag_arbiter: table, directed and random checks of mag_arbiter against a queue-based model
module tb_mag_arbiter;
  localparam int DW = 16, NC = 4, ML = 3, CW = 2;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0;
  always #5 clock = ~clock;
  mag_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .CH_W(CW)) bus ();
`ifdef MAG_ARB_THRESH_EN
  logic [DW-1:0] thresh = DW'(100);
  logic [NC-1:0] out_over;
`endif
  mag_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAG_LATENCY(ML), .CH_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
`ifdef MAG_ARB_THRESH_EN
    .thresh(thresh),
    .out_over(out_over),
`endif
    .bus(bus)
  );
  function automatic logic [DW-1:0] amag(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    int a, b;
    a = i < 0 ? -int'(i) : int'(i);
    b = q < 0 ? -int'(q) : int'(q);
    return DW'(a > b ? a + (b >> 2) : b + (a >> 2));
  endfunction
  logic fix_data = 1'b0, force_stb = 1'b0, mask_stb = 1'b0, dp_keep = 1'b0;
  logic [ML-1:0] dpv;
  logic [DW-1:0] dpm [ML];
  always @(posedge clock)
    if (reset && !dp_keep) dpv <= '0;
    else if (enable) begin
      dpv <= {dpv[ML-2:0], bus.dp_valid};
      dpm[0] <= amag(bus.dp_i, bus.dp_q);
      for (int k = 1; k < ML; k++) dpm[k] <= dpm[k-1];
    end
  assign bus.dp_mag_stb = (dpv[ML-1] & ~mask_stb) | force_stb;
  assign bus.dp_mag = dpm[ML-1];
  typedef struct { int due; int ch; logic [DW-1:0] mag; } res_t;
  res_t pend[$];
  int m_rr = 0, m_en = 0, passed = 0, total = 0, e, lat;
  logic en;
  logic seen_ov;
  logic [CW-1:0] seen_ch, ch;
  logic [DW-1:0] seen_mag, mg;
  logic [NC-1:0] seen_rdy;
  typedef struct packed { logic en; logic [NC-1:0] v; logic [NC-1:0] rdy; } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic cyc(input logic cen, input logic [NC-1:0] v);
    int g;
    logic ev;
    enable = cen;
    bus.req_valid = v;
    if (!fix_data)
      for (int k = 0; k < NC; k++) begin
        bus.req_i[k*DW +: DW] = DW'($urandom());
        bus.req_q[k*DW +: DW] = DW'($urandom());
      end
    @(negedge clock);
    g = -1;
    if (cen && !reset)
      for (int j = 0; j < NC; j++)
        if (v[(m_rr + j) % NC]) begin
          g = (m_rr + j) % NC;
          break;
        end
    seen_rdy = bus.req_ready;
    seen_ov = bus.out_valid;
    seen_ch = bus.out_ch;
    seen_mag = bus.out_mag;
    chk("req_ready", 64'(bus.req_ready), 64'(g < 0 ? 0 : 1 << g));
    if (cen) m_en++;
    ev = cen && pend.size() > 0 && pend[0].due == m_en;
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev) begin
      chk("out_ch", 64'(bus.out_ch), 64'(pend[0].ch));
      chk("out_mag", 64'(bus.out_mag), 64'(pend[0].mag));
      void'(pend.pop_front());
    end
    if (g >= 0) begin
      pend.push_back('{m_en + ML + 2, g, amag(bus.req_i[g*DW +: DW], bus.req_q[g*DW +: DW])});
      m_rr = (g + 1) % NC;
    end
    if (reset) begin
      pend.delete();
      m_rr = 0;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset(input logic cen);
    reset = 1'b1;
    cyc(cen, '1);
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1'b1, 4'b0000, 4'b0000};
    tbl[1] = '{1'b1, 4'b0010, 4'b0010};
    tbl[2] = '{1'b1, 4'b1010, 4'b1000};
    tbl[3] = '{1'b1, 4'b1010, 4'b0010};
    tbl[4] = '{1'b0, 4'b1010, 4'b0000};
    tbl[5] = '{1'b1, 4'b1111, 4'b0100};
    tbl[6] = '{1'b1, 4'b0001, 4'b0001};
    tbl[7] = '{1'b1, 4'b0001, 4'b0001};
    tbl[8] = '{1'b1, 4'b1111, 4'b0010};
    tbl[9] = '{1'b1, 4'b1001, 4'b1000};
    enable = 1'b1;
    bus.req_valid = '1;
    bus.req_i = '0;
    bus.req_q = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_dp_valid", 64'(bus.dp_valid), 64'(0));
    chk("rst_dp_i", 64'(bus.dp_i), 64'(0));
    chk("rst_dp_q", 64'(bus.dp_q), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_mag", 64'(bus.out_mag), 64'(0));
    chk("rst_out_ch", 64'(bus.out_ch), 64'(0));
    chk("rst_tag_err", 64'(bus.tag_err), 64'(0));
    reset = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].en, tbl[i].v);
      chk("table_ready", 64'(seen_rdy), 64'(tbl[i].rdy));
    end
    repeat (ML + 3) cyc(1'b1, '0);
    do_reset(1'b1);
    fix_data = 1'b1;
    bus.req_i = '0;
    bus.req_q = '0;
    bus.req_i[2*DW +: DW] = DW'(3);
    bus.req_q[2*DW +: DW] = DW'(-4);
    cyc(1'b1, 4'b0100);
    chk("single_ready", 64'(seen_rdy), 64'(4'b0100));
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      cyc(1'b1, '0);
      if (seen_ov) begin
        lat = c;
        ch = seen_ch;
        mg = seen_mag;
      end
    end
    chk("single_latency", 64'(lat), 64'(5));
    chk("single_ch", 64'(ch), 64'(2));
    chk("single_mag", 64'(mg), 64'(4));
    fix_data = 1'b0;
    do_reset(1'b1);
    e = 0;
    for (int c = 0; c < 26; c++) begin
      en = !(c == 16 || c == 17);
      cyc(en, '1);
      if (en) begin
        chk("rr_grant", 64'(seen_rdy), 64'(1 << (e % NC)));
        chk("rr_out_valid", 64'(seen_ov), 64'(e >= ML + 2));
        if (e >= ML + 2) chk("rr_out_ch", 64'(seen_ch), 64'((e - ML - 2) % NC));
        e++;
      end else begin
        chk("stall_out_valid", 64'(seen_ov), 64'(0));
        chk("stall_ready", 64'(seen_rdy), 64'(0));
      end
    end
    do_reset(1'b1);
    cyc(1'b1, 4'b0001);
    repeat (3) cyc(1'b1, '0);
    mask_stb = 1'b1;
    cyc(1'b1, '0);
    mask_stb = 1'b0;
    pend.delete();
    cyc(1'b1, '0);
    chk("drop_tag_err", 64'(bus.tag_err), 64'(1));
    do_reset(1'b1);
    repeat (ML + 2) cyc(1'b1, '0);
    chk("stray_before", 64'(bus.tag_err), 64'(0));
    force_stb = 1'b1;
    cyc(1'b1, '0);
    force_stb = 1'b0;
    cyc(1'b1, '0);
    chk("stray_set", 64'(bus.tag_err), 64'(1));
    cyc(1'b0, '0);
    cyc(1'b1, '0);
    chk("stray_hold", 64'(bus.tag_err), 64'(1));
    do_reset(1'b0);
    chk("stray_clear", 64'(bus.tag_err), 64'(0));
    do_reset(1'b1);
    dp_keep = 1'b1;
    repeat (6) cyc(1'b1, '1);
    do_reset(1'b1);
    repeat (ML + 3) cyc(1'b1, '0);
    chk("flush_tag_err", 64'(bus.tag_err), 64'(0));
    dp_keep = 1'b0;
`ifdef MAG_ARB_THRESH_EN
    do_reset(1'b1);
    fix_data = 1'b1;
    bus.req_i = '0;
    bus.req_q = '0;
    bus.req_i[DW-1:0] = DW'(120);
    cyc(1'b1, 4'b0001);
    repeat (ML + 2) cyc(1'b1, '0);
    chk("thresh_over", 64'(out_over), 64'(4'b0001));
    fix_data = 1'b0;
`endif
    do_reset(1'b1);
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(99) == 0);
      cyc($urandom_range(9) != 0, NC'($urandom()));
      reset = 1'b0;
    end
    repeat (ML + 3) cyc(1'b1, '0);
    chk("random_tag_err", 64'(bus.tag_err), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
